// File: rtl/ttc_pkg.sv
// Shared types and default timing constants for the TTC receive-link supervisor.
package ttc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_A = 3'd1,
        ST_GNT_B = 3'd2,
        ST_RST_A = 3'd3,
        ST_RST_B = 3'd4,
        ST_FATAL = 3'd5
    } link_state_t;

    localparam logic [23:0] TTC_RX_TIMEOUT = 24'h186A00;
    localparam int          TTC_RST_PULSE  = 16;
    localparam int          TTC_HOLDOFF    = 256;
    localparam int          TTC_MAX_RETRY  = 3;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rx_chan_guard.sv
// Per-channel bookkeeping: consecutive-timeout retry count, fault flag,
// post-reset holdoff timer and the masked request seen by the arbiter.
module rx_chan_guard
    import ttc_pkg::*;
#(
    parameter int HOLDOFF   = TTC_HOLDOFF,
    parameter int MAX_RETRY = TTC_MAX_RETRY
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic chan_rst_n,
    input  logic timeout_hit,
    input  logic success,
    input  logic pulse_done,
    output logic mreq,
    output logic fault,
    output logic retry_max
);

    localparam int HW = cnt_width(HOLDOFF);
    localparam int RW = cnt_width(MAX_RETRY);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    logic [HW-1:0] holdoff;
    logic [RW-1:0] retry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry   <= '0;
            fault   <= 1'b0;
            holdoff <= '0;
        end else begin
            if (success) begin
                retry <= '0;
                fault <= 1'b0;
            end else if (timeout_hit) begin
                if (retry != RETRY_LIM)
                    retry <= retry + 1'b1;
                fault <= 1'b1;
            end

            // Holdoff keeps running whatever the arbiter does with the other channel.
            if (pulse_done)
                holdoff <= HOLD_LOAD;
            else if (holdoff != '0)
                holdoff <= holdoff - 1'b1;
        end
    end

    assign mreq      = req && (holdoff == '0) && chan_rst_n;
    assign retry_max = (retry == RETRY_LIM);

endmodule

// File: rtl/rx_link_supervisor.sv
// Round-robin arbiter for the shared telecommand frame decoder with per-frame
// busy timeout, per-channel reset pulse, holdoff and sticky system reset request.
//
// state    | meaning
// IDLE     | decoder free, arbitrating masked requests
// GNT_A/B  | decoder owned by channel, busy timer running
// RST_A/B  | channel reset pulse after a timeout
// FATAL    | retries exhausted, system reset requested until rst
module rx_link_supervisor
    import ttc_pkg::*;
#(
    parameter int               CNT_W     = 24,
    parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(TTC_RX_TIMEOUT),
    parameter int               RST_PULSE = TTC_RST_PULSE,
    parameter int               HOLDOFF   = TTC_HOLDOFF,
    parameter int               MAX_RETRY = TTC_MAX_RETRY
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic grant_a,
    output logic grant_b,
    output logic chan_rst_n_a,
    output logic chan_rst_n_b,
    output logic fault_a,
    output logic fault_b,
    output logic sys_rst_n
);

    localparam int               PW           = cnt_width(RST_PULSE);
    localparam logic [PW-1:0]    PULSE_LAST   = PW'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT - 1'b1;

    link_state_t      state;
    link_state_t      state_next;
    logic [CNT_W-1:0] tcnt;
    logic [PW-1:0]    pcnt;
    logic             last_b;

    logic mreq_a, mreq_b;
    logic retry_max_a, retry_max_b;
    logic timeout_hit_a, timeout_hit_b;
    logic success_a, success_b;
    logic pulse_done_a, pulse_done_b;

    rx_chan_guard #(.HOLDOFF(HOLDOFF), .MAX_RETRY(MAX_RETRY)) u_guard_a (
        .clk         (clk),
        .rst         (rst),
        .req         (req_a),
        .chan_rst_n  (chan_rst_n_a),
        .timeout_hit (timeout_hit_a),
        .success     (success_a),
        .pulse_done  (pulse_done_a),
        .mreq        (mreq_a),
        .fault       (fault_a),
        .retry_max   (retry_max_a)
    );

    rx_chan_guard #(.HOLDOFF(HOLDOFF), .MAX_RETRY(MAX_RETRY)) u_guard_b (
        .clk         (clk),
        .rst         (rst),
        .req         (req_b),
        .chan_rst_n  (chan_rst_n_b),
        .timeout_hit (timeout_hit_b),
        .success     (success_b),
        .pulse_done  (pulse_done_b),
        .mreq        (mreq_b),
        .fault       (fault_b),
        .retry_max   (retry_max_b)
    );

    always_comb begin
        state_next    = state;
        timeout_hit_a = 1'b0;
        timeout_hit_b = 1'b0;
        success_a     = 1'b0;
        success_b     = 1'b0;
        pulse_done_a  = 1'b0;
        pulse_done_b  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mreq_a && mreq_b)
                    state_next = last_b ? ST_GNT_A : ST_GNT_B;
                else if (mreq_a)
                    state_next = ST_GNT_A;
                else if (mreq_b)
                    state_next = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (done_a) begin
                    success_a  = 1'b1;
                    state_next = ST_IDLE;
                end else if (!req_a) begin
                    state_next = ST_IDLE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    timeout_hit_a = 1'b1;
                    state_next    = ST_RST_A;
                end
            end
            ST_GNT_B: begin
                if (done_b) begin
                    success_b  = 1'b1;
                    state_next = ST_IDLE;
                end else if (!req_b) begin
                    state_next = ST_IDLE;
                end else if (tcnt == TIMEOUT_LAST) begin
                    timeout_hit_b = 1'b1;
                    state_next    = ST_RST_B;
                end
            end
            ST_RST_A: begin
                if (pcnt == '0) begin
                    pulse_done_a = 1'b1;
                    state_next   = retry_max_a ? ST_FATAL : ST_IDLE;
                end
            end
            ST_RST_B: begin
                if (pcnt == '0) begin
                    pulse_done_b = 1'b1;
                    state_next   = retry_max_b ? ST_FATAL : ST_IDLE;
                end
            end
            ST_FATAL: state_next = ST_FATAL;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            tcnt         <= '0;
            pcnt         <= '0;
            last_b       <= 1'b1;
            grant_a      <= 1'b0;
            grant_b      <= 1'b0;
            chan_rst_n_a <= 1'b1;
            chan_rst_n_b <= 1'b1;
            sys_rst_n    <= 1'b1;
        end else begin
            state <= state_next;

            // Busy timer only counts while a grant is held; IDLE always precedes GNT.
            if (state == ST_GNT_A || state == ST_GNT_B) begin
                if (tcnt != TIMEOUT_LAST)
                    tcnt <= tcnt + 1'b1;
            end else begin
                tcnt <= '0;
            end

            if (timeout_hit_a || timeout_hit_b)
                pcnt <= PULSE_LAST;
            else if (pcnt != '0)
                pcnt <= pcnt - 1'b1;

            if (state == ST_GNT_A && state_next != ST_GNT_A)
                last_b <= 1'b0;
            else if (state == ST_GNT_B && state_next != ST_GNT_B)
                last_b <= 1'b1;

            grant_a      <= (state_next == ST_GNT_A);
            grant_b      <= (state_next == ST_GNT_B);
            chan_rst_n_a <= !(state_next == ST_RST_A || state_next == ST_FATAL);
            chan_rst_n_b <= !(state_next == ST_RST_B || state_next == ST_FATAL);
            sys_rst_n    <= (state_next != ST_FATAL);
        end
    end

endmodule

// File: tb/tb_rx_link_supervisor.sv
// Self-checking bench: cycle model of the supervisor checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_rx_link_supervisor;

    localparam int T_OUT   = 20;
    localparam int T_PULSE = 4;
    localparam int T_HOLD  = 8;
    localparam int T_RETRY = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, done_a = 1'b0, done_b = 1'b0;
    logic grant_a, grant_b, chan_rst_n_a, chan_rst_n_b, fault_a, fault_b, sys_rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    rx_link_supervisor #(
        .CNT_W     (24),
        .TIMEOUT   (24'(T_OUT)),
        .RST_PULSE (T_PULSE),
        .HOLDOFF   (T_HOLD),
        .MAX_RETRY (T_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .req_b        (req_b),
        .done_a       (done_a),
        .done_b       (done_b),
        .grant_a      (grant_a),
        .grant_b      (grant_b),
        .chan_rst_n_a (chan_rst_n_a),
        .chan_rst_n_b (chan_rst_n_b),
        .fault_a      (fault_a),
        .fault_b      (fault_b),
        .sys_rst_n    (sys_rst_n)
    );

    always #5 clk = ~clk;

    // Model: who owns the decoder and for how many cycles, remaining reset-pulse
    // cycles, remaining holdoff, retry/fault per channel, fatal flag, last served.
    int m_owner;       // 0 none, 1 A, 2 B
    int m_held;
    int m_rst_left[2];
    int m_hold[2];
    int m_retry[2];
    int m_fault[2];
    int m_fatal;
    int m_last;        // 0 A, 1 B

    int ga_cnt, gb_cnt, ra_cnt;

    task automatic model_reset();
        m_owner = 0; m_held = 0; m_fatal = 0; m_last = 1;
        for (int c = 0; c < 2; c++) begin
            m_rst_left[c] = 0; m_hold[c] = 0; m_retry[c] = 0; m_fault[c] = 0;
        end
    endtask

    task automatic model_step();
        int req[2], done[2], mreq[2];
        int c;
        req[0] = int'(req_a);   req[1] = int'(req_b);
        done[0] = int'(done_a); done[1] = int'(done_b);
        for (int k = 0; k < 2; k++)
            mreq[k] = (req[k] != 0 && m_hold[k] == 0 && m_rst_left[k] == 0 && m_fatal == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++)
            if (m_hold[k] > 0) m_hold[k]--;
        if (m_fatal != 0) begin
        end else if (m_rst_left[0] > 0 || m_rst_left[1] > 0) begin
            c = (m_rst_left[0] > 0) ? 0 : 1;
            m_rst_left[c]--;
            if (m_rst_left[c] == 0) begin
                if (m_retry[c] == T_RETRY) m_fatal = 1;
                else m_hold[c] = T_HOLD;
            end
        end else if (m_owner != 0) begin
            c = m_owner - 1;
            if (done[c] != 0) begin
                m_retry[c] = 0; m_fault[c] = 0; m_owner = 0; m_last = c;
            end else if (req[c] == 0) begin
                m_owner = 0; m_last = c;
            end else if (m_held == T_OUT) begin
                m_owner = 0; m_last = c; m_fault[c] = 1;
                m_rst_left[c] = T_PULSE;
                if (m_retry[c] < T_RETRY) m_retry[c]++;
            end else begin
                m_held++;
            end
        end else if (mreq[0] != 0 || mreq[1] != 0) begin
            if (mreq[0] != 0 && mreq[1] != 0) c = (m_last == 0) ? 1 : 0;
            else c = (mreq[0] != 0) ? 0 : 1;
            m_owner = c + 1;
            m_held = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) if (rst) model_step();

    always @(negedge clk) begin
        check("grant_a",      int'(grant_a),      (m_owner == 1) ? 1 : 0);
        check("grant_b",      int'(grant_b),      (m_owner == 2) ? 1 : 0);
        check("chan_rst_n_a", int'(chan_rst_n_a), (m_rst_left[0] > 0 || m_fatal != 0) ? 0 : 1);
        check("chan_rst_n_b", int'(chan_rst_n_b), (m_rst_left[1] > 0 || m_fatal != 0) ? 0 : 1);
        check("fault_a",      int'(fault_a),      m_fault[0]);
        check("fault_b",      int'(fault_b),      m_fault[1]);
        check("sys_rst_n",    int'(sys_rst_n),    (m_fatal != 0) ? 0 : 1);
        check("grant_overlap", int'(grant_a & grant_b), 0);
        if (rst) begin
            if (grant_a) ga_cnt++;
            if (grant_b) gb_cnt++;
            if (!chan_rst_n_a) ra_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Hold reset for two cycles; reqs for the next scenario are set before release.
    task automatic apply_reset(input logic ra, input logic rb);
        rst = 1'b0;
        req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
        model_reset();
        tick(2);
        req_a = ra; req_b = rb;
        ga_cnt = 0; gb_cnt = 0; ra_cnt = 0;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        ga_cnt = 0; gb_cnt = 0; ra_cnt = 0;

        // 1: simultaneous requests, A wins first tie, B follows after A's done.
        apply_reset(1'b1, 1'b1);
        tick(1);
        check("s1_first_grant_a", int'(grant_a), 1);
        check("s1_first_grant_b", int'(grant_b), 0);
        tick(2);
        done_a = 1'b1;
        tick(1);
        done_a = 1'b0;
        check("s1_release_a", int'(grant_a), 0);
        tick(1);
        check("s1_grant_b", int'(grant_b), 1);
        req_a = 1'b0;
        done_b = 1'b1;
        tick(1);
        done_b = 1'b0; req_b = 1'b0;
        tick(2);

        // 2: timeout on A, reset pulse, holdoff of 8 cycles.
        apply_reset(1'b1, 1'b0);
        tick(33);
        check("s2_grant_cycles", ga_cnt, 20);
        check("s2_rst_cycles", ra_cnt, 4);
        check("s2_fault_a", int'(fault_a), 1);
        check("s2_held_off", int'(grant_a), 0);
        tick(1);
        check("s2_regrant", int'(grant_a), 1);
        req_a = 1'b0;
        tick(2);

        // 3: B served during A's holdoff, A served after B completes.
        apply_reset(1'b1, 1'b0);
        tick(24);
        req_b = 1'b1;
        tick(2);
        check("s3_grant_b", int'(grant_b), 1);
        tick(10);
        check("s3_a_waits", int'(grant_a), 0);
        done_b = 1'b1;
        tick(1);
        done_b = 1'b0; req_b = 1'b0;
        tick(1);
        check("s3_grant_a", int'(grant_a), 1);
        req_a = 1'b0;
        tick(2);

        // 4: two consecutive timeouts escalate to the sticky system reset.
        apply_reset(1'b1, 1'b0);
        tick(58);
        check("s4_sys_rst_n", int'(sys_rst_n), 0);
        check("s4_chan_rst_n_b", int'(chan_rst_n_b), 0);
        req_b = 1'b1;
        tick(10);
        check("s4_sticky", int'(sys_rst_n), 0);
        check("s4_no_grant_b", int'(grant_b), 0);
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        model_reset();
        #1;
        check("s4_rst_sys", int'(sys_rst_n), 1);
        check("s4_rst_fault", int'(fault_a), 0);
        tick(1);

        // 5: success after a timeout clears fault/retry; next timeout is not fatal.
        apply_reset(1'b1, 1'b0);
        tick(36);
        done_a = 1'b1;
        tick(1);
        done_a = 1'b0;
        check("s5_fault_cleared", int'(fault_a), 0);
        tick(25);
        check("s5_not_fatal", int'(sys_rst_n), 1);
        check("s5_fault_again", int'(fault_a), 1);
        check("s5_chan_released", int'(chan_rst_n_a), 1);
        req_a = 1'b0;
        tick(2);

        // 6: done on last grant cycle wins; stray done_b ignored; reset during RST_A.
        apply_reset(1'b1, 1'b0);
        tick(5);
        done_b = 1'b1;
        tick(1);
        done_b = 1'b0;
        check("s6_done_b_ignored", int'(grant_a), 1);
        tick(14);
        done_a = 1'b1;
        tick(1);
        done_a = 1'b0;
        check("s6_done_wins_grant", int'(grant_a), 0);
        check("s6_done_wins_rst", int'(chan_rst_n_a), 1);
        check("s6_done_wins_fault", int'(fault_a), 0);
        tick(22);
        check("s6_in_pulse", int'(chan_rst_n_a), 0);
        rst = 1'b0; req_a = 1'b0;
        model_reset();
        #1;
        check("s6_async_release", int'(chan_rst_n_a), 1);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
